// File: rtl/fx_pkg.sv
// Shared constants for the FX command parser: the address width, the two
// opcodes the host may send, and the parser state encoding.
package fx_pkg;

  localparam int FX_AW = 22;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  // State encoding kept as plain constants so legacy tools and probes can
  // match on raw values.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_A2       = 4'd1;
  localparam logic [3:0] ST_A1       = 4'd2;
  localparam logic [3:0] ST_A0       = 4'd3;
  localparam logic [3:0] ST_ARG      = 4'd4;
  localparam logic [3:0] ST_WR       = 4'd5;
  localparam logic [3:0] ST_RD_ISSUE = 4'd6;
  localparam logic [3:0] ST_RD_CAP   = 4'd7;
  localparam logic [3:0] ST_RD_SEND  = 4'd8;

  // True for the bytes that may legally start a packet.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/fx_cmd_parser_if.sv
// Bundles the byte streams to and from the USB FIFO side together with the
// write/read bus toward control_top. The parser is the master of this bundle;
// the surrounding system (FIFO logic, control_top or a bench) is the slave.
interface fx_cmd_parser_if;
  import fx_pkg::*;

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [FX_AW-1:0] fx_waddr;
  logic             fx_wr;
  logic [7:0]       fx_data;
  logic             fx_rd;
  logic [FX_AW-1:0] fx_raddr;
  logic [7:0]       fx_q;

  modport master (
    input  rx_data, rx_valid, tx_ready, fx_q,
    output rx_ready, tx_data, tx_valid, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, fx_q,
    input  rx_ready, tx_data, tx_valid, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
  );

endinterface

// File: rtl/fx_cmd_parser.sv
// Byte-stream command parser. Collects five-byte packets (opcode, three
// address bytes, argument) from the host and turns them into a single write
// strobe or a burst of reads whose data is streamed back byte by byte.
// Partial packets are abandoned after TIMEOUT_CYC quiet cycles; malformed
// openings and timeouts are counted in a saturating error counter.
module fx_cmd_parser
  import fx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  fx_cmd_parser_if.master      bus,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [3:0]        state;
  logic              is_read;
  logic [FX_AW-1:0]  addr_reg;
  logic [7:0]        arg_reg;
  logic [7:0]        tx_data_reg;
  logic              tx_valid_reg;
  logic [IDLE_W-1:0] idle_cnt;

  logic in_header;
  logic rx_ready_int;
  logic rx_fire;
  logic tx_fire;
  logic bad_opcode;
  logic timeout_hit;
  logic proto_err;

  // Handshake and error qualifiers, all derived from the current state.
  always_comb begin
    in_header    = (state == ST_A2) || (state == ST_A1) ||
                   (state == ST_A0) || (state == ST_ARG);
    rx_ready_int = (state == ST_IDLE) || in_header;
    rx_fire      = bus.rx_valid && rx_ready_int;
    tx_fire      = tx_valid_reg && bus.tx_ready;
    bad_opcode   = (state == ST_IDLE) && rx_fire && !is_opcode(bus.rx_data);
    timeout_hit  = in_header && !rx_fire && (idle_cnt == IDLE_LAST);
    proto_err    = bad_opcode || timeout_hit;
  end

  assign bus.rx_ready = rx_ready_int;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.fx_waddr = addr_reg;
  assign bus.fx_raddr = addr_reg;
  assign bus.fx_data  = arg_reg;
  assign bus.fx_wr    = (state == ST_WR);
  assign bus.fx_rd    = (state == ST_RD_ISSUE);
  assign busy         = (state != ST_IDLE);

  // Packet FSM: header collection, the write strobe, and the read loop
  // (issue, capture, hand back one byte at a time).
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state        <= ST_IDLE;
      is_read      <= 1'b0;
      addr_reg     <= '0;
      arg_reg      <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire && is_opcode(bus.rx_data)) begin
            is_read <= (bus.rx_data == OP_RD);
            state   <= ST_A2;
          end
        end
        ST_A2: begin
          if (rx_fire) begin
            addr_reg[21:16] <= bus.rx_data[5:0];
            state           <= ST_A1;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_A1: begin
          if (rx_fire) begin
            addr_reg[15:8] <= bus.rx_data;
            state          <= ST_A0;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_A0: begin
          if (rx_fire) begin
            addr_reg[7:0] <= bus.rx_data;
            state         <= ST_ARG;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_ARG: begin
          if (rx_fire) begin
            arg_reg <= bus.rx_data;
            state   <= is_read ? ST_RD_ISSUE : ST_WR;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_WR: begin
          state <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          tx_data_reg  <= bus.fx_q;
          tx_valid_reg <= 1'b1;
          state        <= ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (tx_fire) begin
            tx_valid_reg <= 1'b0;
            if (arg_reg == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              addr_reg <= addr_reg + FX_AW'(1);
              arg_reg  <= arg_reg - 8'd1;
              state    <= ST_RD_ISSUE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Quiet-cycle counter; only runs while a header is half-collected.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!in_header || rx_fire || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Saturating protocol error count; one step per cycle at most.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (proto_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fx_cmd_parser.sv
// Bench for fx_cmd_parser: a table of complete packets with hand-computed
// addresses and counts, followed by hand-written sequences for backpressure,
// header timeout, reset during a long burst and error-counter saturation.
module tb_fx_cmd_parser;
  import fx_pkg::*;

  localparam int TO_CYC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] err_cnt;

  fx_cmd_parser_if bus ();

  fx_cmd_parser #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic             pre_bad;
    logic [7:0]       op;
    logic [7:0]       a2;
    logic [7:0]       a1;
    logic [7:0]       a0;
    logic [7:0]       arg;
    logic             q_const;
    logic             exp_read;
    logic [FX_AW-1:0] exp_addr;
    logic [8:0]       exp_n;
    logic [7:0]       exp_wdata;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_err      = 0;
  logic q_const_mode = 1'b0;

  logic [FX_AW-1:0] wr_addr_q [$];
  logic [7:0]       wr_data_q [$];
  logic [FX_AW-1:0] rd_addr_q [$];
  logic [7:0]       tx_q      [$];

  // Read-data source: answers each fx_rd one cycle later.
  always @(posedge clk) begin
    if (bus.fx_rd) bus.fx_q <= q_const_mode ? 8'hA5 : (bus.fx_raddr[7:0] ^ 8'h3C);
  end

  // Record every write strobe, read strobe and completed tx transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fx_wr) begin
        wr_addr_q.push_back(bus.fx_waddr);
        wr_data_q.push_back(bus.fx_data);
      end
      if (bus.fx_rd) rd_addr_q.push_back(bus.fx_raddr);
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    end
  end

  function automatic logic [7:0] qModel(input logic [FX_AW-1:0] a, input logic qc);
    return qc ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: wait bound expired, event never seen", name);
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
  endtask

  // Offer one byte on rx and hold it until the parser takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int  waited = 0;
    bit  done   = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.rx_ready) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          failNow("rx_accept");
          done = 1;
        end
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) failNow(name);
  endtask

  task automatic sendPacket(input vec_t v);
    applyStimulus(v.op);
    applyStimulus(v.a2);
    applyStimulus(v.a1);
    applyStimulus(v.a0);
    applyStimulus(v.arg);
  endtask

  task automatic runVector(input vec_t v, input int idx);
    logic [FX_AW-1:0] a;
    clearLogs();
    q_const_mode = v.q_const;
    if (v.pre_bad) begin
      applyStimulus(8'h00);
      exp_err++;
    end
    sendPacket(v);
    waitIdle($sformatf("v%0d idle", idx));
    if (!v.exp_read) begin
      checkOutput($sformatf("v%0d wr_count", idx), wr_addr_q.size(), 1);
      checkOutput($sformatf("v%0d rd_count", idx), rd_addr_q.size(), 0);
      if (wr_addr_q.size() > 0) begin
        checkOutput($sformatf("v%0d fx_waddr", idx), 32'(wr_addr_q[0]), 32'(v.exp_addr));
        checkOutput($sformatf("v%0d fx_data", idx), 32'(wr_data_q[0]), 32'(v.exp_wdata));
      end
    end else begin
      checkOutput($sformatf("v%0d wr_count", idx), wr_addr_q.size(), 0);
      checkOutput($sformatf("v%0d rd_count", idx), rd_addr_q.size(), 32'(v.exp_n));
      checkOutput($sformatf("v%0d tx_count", idx), tx_q.size(), 32'(v.exp_n));
      for (int i = 0; i < int'(v.exp_n); i++) begin
        a = v.exp_addr + FX_AW'(i);
        if (i < rd_addr_q.size())
          checkOutput($sformatf("v%0d fx_raddr[%0d]", idx, i), 32'(rd_addr_q[i]), 32'(a));
        if (i < tx_q.size())
          checkOutput($sformatf("v%0d tx_data[%0d]", idx, i), 32'(tx_q[i]), 32'(qModel(a, v.q_const)));
      end
    end
    checkOutput($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'(exp_err));
    checkOutput($sformatf("v%0d rx_ready", idx), 32'(bus.rx_ready), 1);
  endtask

  // Main sequence: reset, packet table, then the multi-cycle corner cases.
  initial begin
    int               n;
    int               rd_before;
    int               cycles;
    logic [7:0]       held;
    bit               stall_ok;
    vec_t             v;

    vecs[0] = '{1'b0, 8'h57, 8'h01, 8'h23, 8'h45, 8'hA5, 1'b0, 1'b0, 22'h012345, 9'd1, 8'hA5};
    vecs[1] = '{1'b0, 8'h52, 8'hFF, 8'hFF, 8'hFE, 8'h02, 1'b1, 1'b1, 22'h3FFFFE, 9'd3, 8'h00};
    vecs[2] = '{1'b0, 8'h57, 8'hC0, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 22'h000000, 9'd1, 8'h3C};
    vecs[3] = '{1'b0, 8'h52, 8'h12, 8'h34, 8'h56, 8'h00, 1'b0, 1'b1, 22'h123456, 9'd1, 8'h00};
    vecs[4] = '{1'b0, 8'h57, 8'h3F, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 22'h3FFFFF, 9'd1, 8'h00};
    vecs[5] = '{1'b0, 8'h52, 8'h00, 8'h00, 8'hFE, 8'h03, 1'b0, 1'b1, 22'h0000FE, 9'd4, 8'h00};
    vecs[6] = '{1'b1, 8'h57, 8'h01, 8'h23, 8'h45, 8'hA5, 1'b0, 1'b0, 22'h012345, 9'd1, 8'hA5};
    vecs[7] = '{1'b0, 8'h52, 8'h7F, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 22'h3FFFFF, 9'd2, 8'h00};

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset tx_valid", 32'(bus.tx_valid), 0);
    checkOutput("reset fx_wr", 32'(bus.fx_wr), 0);
    checkOutput("reset fx_rd", 32'(bus.fx_rd), 0);
    checkOutput("reset err_cnt", 32'(err_cnt), 0);
    checkOutput("reset fx_waddr", 32'(bus.fx_waddr), 0);
    checkOutput("reset fx_raddr", 32'(bus.fx_raddr), 0);
    checkOutput("reset fx_data", 32'(bus.fx_data), 0);
    checkOutput("reset tx_data", 32'(bus.tx_data), 0);
    checkOutput("reset rx_ready", 32'(bus.rx_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) runVector(vecs[i], i);

    // Backpressure: stall the third byte of a six-byte burst for 10 cycles.
    clearLogs();
    q_const_mode = 1'b0;
    v = '{1'b0, 8'h52, 8'h00, 8'h10, 8'h00, 8'h05, 1'b0, 1'b1, 22'h001000, 9'd6, 8'h00};
    sendPacket(v);
    n = 0;
    while (tx_q.size() < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tx_q.size() < 2) failNow("bp first bytes");
    bus.tx_ready = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.tx_valid) failNow("bp tx_valid");
    rd_before = rd_addr_q.size();
    held      = bus.tx_data;
    stall_ok  = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!bus.tx_valid || bus.tx_data !== held) stall_ok = 0;
    end
    checkOutput("bp held byte", 32'(held), 32'(qModel(22'h001002, 1'b0)));
    checkOutput("bp tx held steady", 32'(stall_ok), 1);
    checkOutput("bp reads before stall", rd_before, 3);
    checkOutput("bp no fx_rd in stall", rd_addr_q.size(), rd_before);
    checkOutput("bp no tx in stall", tx_q.size(), 2);
    bus.tx_ready = 1'b1;
    waitIdle("bp idle");
    checkOutput("bp tx_count", tx_q.size(), 6);
    checkOutput("bp rd_count", rd_addr_q.size(), 6);
    for (int i = 0; i < 6 && i < tx_q.size(); i++)
      checkOutput($sformatf("bp tx_data[%0d]", i), 32'(tx_q[i]), 32'(qModel(22'h001000 + FX_AW'(i), 1'b0)));

    // Timeout: half a header, then silence.
    clearLogs();
    applyStimulus(8'h57);
    applyStimulus(8'h01);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    exp_err++;
    checkOutput("timeout cycles", cycles, TO_CYC);
    checkOutput("timeout err_cnt", 32'(err_cnt), 32'(exp_err));
    checkOutput("timeout no fx_wr", wr_addr_q.size(), 0);
    checkOutput("timeout rx_ready", 32'(bus.rx_ready), 1);

    // Reset in the middle of a 256-byte burst.
    clearLogs();
    v = '{1'b0, 8'h52, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 22'h000000, 9'd256, 8'h00};
    sendPacket(v);
    n = 0;
    while (rd_addr_q.size() < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rd_addr_q.size() < 5) failNow("burst start");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst busy", 32'(busy), 0);
    checkOutput("midrst tx_valid", 32'(bus.tx_valid), 0);
    checkOutput("midrst fx_rd", 32'(bus.fx_rd), 0);
    checkOutput("midrst fx_raddr", 32'(bus.fx_raddr), 0);
    checkOutput("midrst tx_data", 32'(bus.tx_data), 0);
    checkOutput("midrst err_cnt", 32'(err_cnt), 0);
    exp_err = 0;
    rst = 1'b0;
    rd_before = rd_addr_q.size();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst no further fx_rd", rd_addr_q.size(), rd_before);
    v = '{1'b0, 8'h57, 8'h2A, 8'hBC, 8'hDE, 8'h77, 1'b0, 1'b0, 22'h2ABCDE, 9'd1, 8'h77};
    runVector(v, 100);

    // Error counter saturation with a run of junk bytes.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(8'hFF);
      if (exp_err < 255) exp_err++;
    end
    checkOutput("err_cnt saturate", 32'(err_cnt), 32'(exp_err));
    checkOutput("err_cnt after junk busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fx_cmd_parser.md
FX_CMD_PARSER -- requirements
Module: fx_cmd_parser

Interface
REQ-001 SHALL be built for one clock; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT_CYC, default 50000: cycles without an accepted byte before a partial packet is abandoned.
REQ-003 clk_sys  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rx_data  input  8  command byte from the USB FIFO side.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  parser accepts rx_data; a byte transfers when rx_valid && rx_ready.
REQ-008 tx_data  output  8  read-return byte to the USB FIFO side.
REQ-009 tx_valid  output  1  tx_data valid.
REQ-010 tx_ready  input  1  sink accepts tx_data; a byte transfers when tx_valid && tx_ready.
REQ-011 fx_waddr  output  22  write address to control_top.
REQ-012 fx_wr  output  1  one-cycle write strobe.
REQ-013 fx_data  output  8  write data.
REQ-014 fx_rd  output  1  one-cycle read strobe.
REQ-015 fx_raddr  output  22  read address.
REQ-016 fx_q  input  8  read data, valid the cycle after fx_rd.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err_cnt  output  8  count of protocol errors, saturating at 0xFF.

Function
REQ-019 Packet format: opcode, ADDR2, ADDR1, ADDR0, ARG; address = {ADDR2[5:0], ADDR1, ADDR0}; ADDR2[7:6] ignored.
REQ-020 Opcode 0x57 = single write of ARG; opcode 0x52 = burst read of ARG+1 bytes (1..256).
REQ-021 States: IDLE, A2, A1, A0, ARG, WR, RD_ISSUE, RD_CAP, RD_SEND.
REQ-022 rx_ready SHALL be 1 only in IDLE, A2, A1, A0 and ARG, driven combinationally from state.
REQ-023 IDLE: on accepted 0x57/0x52, latch opcode -> A2; any other accepted byte -> stay IDLE, err_cnt+1.
REQ-024 A2/A1/A0: each accepted byte loads its address field and advances; ARG: accepted byte loads data/count register, then -> WR (write) or RD_ISSUE (read).
REQ-025 WR: fx_wr=1 for exactly one cycle with fx_waddr/fx_data stable -> IDLE.
REQ-026 RD_ISSUE: fx_rd=1 for exactly one cycle -> RD_CAP; RD_CAP: tx_data<=fx_q, tx_valid<=1 -> RD_SEND.
REQ-027 RD_SEND: hold tx_data/tx_valid until handshake; on handshake tx_valid<=0; if remaining==0 -> IDLE, else addr+1, remaining-1 -> RD_ISSUE.
REQ-028 The address increment SHALL wrap modulo 2^22 (0x3FFFFF -> 0x000000).
REQ-029 Under backpressure, no new fx_rd SHALL issue while tx_valid=1; nominal throughput is one byte per 3 cycles.
REQ-030 fx_waddr and fx_raddr SHALL both continuously reflect the address register; fx_data reflects the data register.
REQ-031 Timeout: in A2..ARG, an idle counter increments each cycle without an accepted byte and clears on an accepted byte; when it reaches TIMEOUT_CYC-1 -> IDLE, err_cnt+1.
REQ-032 Timeout SHALL NOT apply in WR/RD_* states (tx backpressure may stall indefinitely).
REQ-033 An error and any other event in the same cycle SHALL increment err_cnt by at most 1.

Reset
REQ-034 rst SHALL force state=IDLE and tx_valid, fx_wr, fx_rd = 0.
REQ-035 rst SHALL clear tx_data, fx_waddr, fx_raddr, fx_data, the count register, the idle counter and err_cnt to 0.
REQ-036 rst asserted mid-burst SHALL abort the burst with no further fx_rd, and the next packet SHALL parse normally.

Structure
REQ-037 Package fx_pkg holds FX_AW=22, OP_WR=8'h57, OP_RD=8'h52 and the state enumeration.
REQ-038 fx_cmd_parser SHALL be a single module; no sub-module is required.

Verification
REQ-039 Write: rx 57 01 23 45 A5 -> one fx_wr pulse with fx_waddr=0x012345, fx_data=0xA5; busy returns low.
REQ-040 Wrap-around read: rx 52 FF FF FE 02 with fx_q=0xA5 -> fx_raddr 0x3FFFFE, 0x3FFFFF, 0x000000; tx emits A5 A5 A5, then IDLE.
REQ-041 Backpressure: tx_ready=0 for 10 cycles mid-burst -> tx_data held, tx_valid=1, no fx_rd pulses; resumes on tx_ready=1.
REQ-042 Bad opcode: rx 00 then a valid write packet -> err_cnt=1; the write executes correctly.
REQ-043 Timeout (TIMEOUT_CYC=16): rx 57 01 then silence -> IDLE after 16 cycles, err_cnt+1, no fx_wr.
REQ-044 Reset mid-burst: rst during a 256-byte read -> outputs at reset values next cycle; a following write packet completes.
